// File: rtl/rv_pkg.sv
// Shared RISC-V constants for the M-extension multiply/divide unit:
// funct3 encodings, opcode/funct7 identifiers, FSM state encoding and
// small operand-classification helpers.
package rv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM
  function automatic logic op_rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is interpreted as signed for MULH, DIV and REM
  function automatic logic op_rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/rv_div_core.sv
// Iterative restoring divider on unsigned magnitudes. One quotient bit is
// produced per asserted step. The quotient/remainder outputs are the values
// that result from the current step, so the parent can capture the final
// answer on the same edge that performs the last step.
module rv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
    quotient  = quo_nxt;
    remainder = rem_nxt;
  end

  // Remainder/quotient shift registers; the quotient register starts out holding the dividend
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// RISC-V M-extension multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with the sign correction applied
// when the result is captured on entry to DONE. Division by zero and signed
// overflow bypass the iteration and complete one cycle after accept.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// full product and also complete one cycle after accept.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | iterating, one radix-2 step per enabled cycle
// DONE  | result valid, held until out_ready
module rv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  import rv_pkg::*;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_a_q;
  logic              neg_b_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              accept;
  logic              step_en;
  logic              finish;

  logic              rs1_neg;
  logic              rs2_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              fast_path;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res;

  // Negate the magnitude product when the operand signs differ, then pick the low or high half
  function automatic logic [XLEN-1:0] mul_select(input logic [2:0] f3,
                                                 input logic [2*XLEN-1:0] prod,
                                                 input logic neg);
    logic [2*XLEN-1:0] full;
    full = neg ? (~prod + 1'b1) : prod;
    return (f3 == F3_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
  endfunction

  // Request decode: magnitudes, sign flags and the single-cycle special cases
  always_comb begin
    rs1_neg  = op_rs1_signed(op) & rs1_val[XLEN-1];
    rs2_neg  = op_rs2_signed(op) & rs2_val[XLEN-1];
    mag_a    = rs1_neg ? (~rs1_val + 1'b1) : rs1_val;
    mag_b    = rs2_neg ? (~rs2_val + 1'b1) : rs2_val;
    div_zero = op_is_div(op) && (rs2_val == '0);
    div_ovf  = ((op == F3_DIV) || (op == F3_REM)) && (rs1_val == MOST_NEG) && (rs2_val == '1);
    fast_res = '0;
    if (div_zero) begin
      fast_res = op[1] ? rs1_val : '1;
    end else if (div_ovf) begin
      fast_res = op[1] ? '0 : MOST_NEG;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_path = div_zero | div_ovf | ~op_is_div(op);
    if (!op_is_div(op)) begin
      fast_res = mul_select(op, {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b}, rs1_neg ^ rs2_neg);
    end
`else
    fast_path = div_zero | div_ovf;
`endif
  end

  // Iteration step results and the sign-corrected final value
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {mul_sum, prod_q[XLEN-1:1]};
    quo_fix   = (neg_a_q ^ neg_b_q) ? (~quotient + 1'b1) : quotient;
    rem_fix   = neg_a_q ? (~remainder + 1'b1) : remainder;
    if (op_is_div(op_q)) begin
      calc_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      calc_res = mul_select(op_q, prod_step, neg_a_q ^ neg_b_q);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes; flush beats any request, enable low freezes everything
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_en   = 1'b0;
    finish    = 1'b0;
    if (enable) begin
      if (flush) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_valid) begin
              accept    = 1'b1;
              state_nxt = fast_path ? ST_DONE : ST_CALC;
            end
          end
          ST_CALC: begin
            step_en = 1'b1;
            if (cnt == LAST_STEP) begin
              finish    = 1'b1;
              state_nxt = ST_DONE;
            end
          end
          ST_DONE: begin
            if (out_ready) begin
              state_nxt = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Operand capture, multiply shift register, step counter and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= op;
      rd_q    <= rd_in;
      neg_a_q <= rs1_neg;
      neg_b_q <= rs2_neg;
      mcand_q <= mag_a;
      prod_q  <= {{XLEN{1'b0}}, mag_b};
      if (fast_path) begin
        result_q <= fast_res;
        rd_out_q <= rd_in;
      end
    end else if (step_en) begin
      cnt    <= cnt + 1'b1;
      prod_q <= prod_step;
      if (finish) begin
        result_q <= calc_res;
        rd_out_q <= rd_q;
      end
    end
  end

  rv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (step_en & op_is_div(op_q)),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign result    = result_q;
  assign rd_out    = rd_out_q;

endmodule

// File: doc/rv_muldiv_unit.md
RV_MULDIV_UNIT -- requirements
Module: rv_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width in bits; legal values are 32 and 64.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port enable  in  1: global advance; when low, all state is frozen.
REQ-005 SHALL have port flush  in  1: aborts the operation in flight, asserted by the core on a taken branch or jump.
REQ-006 SHALL have port in_valid  in  1: the request fields below are valid.
REQ-007 SHALL have port in_ready  out  1: the unit can accept a request this cycle.
REQ-008 SHALL have port op  in  3: M-extension funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-009 SHALL have ports rs1_val and rs2_val  in  XLEN: operands.
REQ-010 SHALL have port rd_in  in  5: destination register tag.
REQ-011 SHALL have port out_valid  out  1: result available.
REQ-012 SHALL have port out_ready  in  1: the consumer takes the result.
REQ-013 SHALL have ports result  out  XLEN and rd_out  out  5.
REQ-014 SHALL have port busy  out  1: high in any state other than IDLE, for stalling by the hazard unit.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 SHALL accept a request on a cycle with enable & in_valid & in_ready & ~flush; in_ready SHALL be high only in IDLE.
REQ-017 SHALL, on accept, latch op, rd_in and the operand magnitudes plus sign flags, then go to CALC with the iteration counter set to 0.
REQ-018 SHALL, in CALC, perform one radix-2 step per enabled cycle (shift-add multiply, restoring divide), then go to DONE after XLEN steps.
REQ-019 SHALL set out_valid exactly XLEN+1 enabled cycles after the accept cycle.
REQ-020 SHALL hold result and rd_out stable in DONE until out_ready is sampled high, then return to IDLE.
REQ-021 SHALL select the result as follows: MUL gives the low XLEN bits of the product; MULH, MULHSU and MULHU give the high XLEN bits with signed/signed, signed/unsigned and unsigned/unsigned operands respectively.
REQ-022 SHALL apply the sign fix in the DONE transition: quotient negated if the operand signs differ; remainder takes the dividend's sign.
REQ-023 SHALL treat division by zero as a fast path: go straight to DONE, with out_valid at accept+1; quotient all-ones, remainder = rs1_val.
REQ-024 SHALL handle signed overflow (DIV/REM of the most-negative value by -1) as a fast path with out_valid at accept+1: quotient = most-negative value, remainder = 0.
REQ-025 SHALL, when flush is high and enable is high, go to IDLE on the next edge and drop out_valid; flush SHALL win over a simultaneous in_valid, which is not accepted.
REQ-026 SHALL, when enable is low, hold the FSM, the counter and all outputs, and ignore flush.

Reset
REQ-027 SHALL, while rst is low, force: state IDLE, counter 0, in_ready 1, out_valid 0, busy 0, result 0, rd_out 0.
REQ-028 SHALL treat reset mid-operation as an abort, with no result delivered.

Configuration
REQ-029 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute all multiply ops with a single-cycle full product: MUL ops go accept -> DONE with out_valid at accept+1, and divide behaviour is unchanged.
REQ-030 SHALL, without MULDIV_FAST_MUL_EN, use iterative multiply per REQ-018 and contain no XLEN x XLEN multiplier.

Structure
REQ-031 SHALL take the following from shared package rv_pkg: the op funct3 localparams, the FSM state encoding, and the M-extension opcode constant 7'b0110011 with funct7 7'b0000001.
REQ-032 SHALL place the iterative restoring-divide datapath (remainder/quotient shift registers) in sub-module rv_div_core; the FSM, multiply path and sign fix stay in rv_muldiv_unit.

Verification
REQ-033 SHALL cover: MUL 7 x -3 (XLEN=32) -> result 0xFFFFFFEB, out_valid at accept+33 (accept+1 with MULDIV_FAST_MUL_EN).
REQ-034 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 SHALL cover: DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-036 SHALL cover: DIV 5 / 0 -> 0xFFFFFFFF at accept+1; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000, with REM -> 0.
REQ-037 SHALL cover: flush at CALC step 10 -> out_valid never rises, and busy is 0 and in_ready is 1 the next cycle; flush with in_valid in IDLE -> not accepted.
REQ-038 SHALL cover: out_ready held low 5 cycles in DONE -> result stable; enable low 3 cycles in CALC -> latency extended by 3; rst low mid-CALC -> outputs at reset values.
